// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, writeback state encoding and
// the writeback holding-register payload.
package core_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 4;

    typedef enum logic [1:0] {
        WB_RUN,
        WB_DRAIN,
        WB_HALTED
    } wb_state_e;

    typedef struct packed {
        logic              wr;
        logic [REG_W-1:0]  rt;
        logic [DATA_W-1:0] val;
        logic              halt;
    } wb_entry_t;

endpackage

// File: rtl/wb_watchdog.sv
// No-retire watchdog: saturating idle counter and a sticky hung flag.
module wb_watchdog #(
    parameter int unsigned WDOG = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic retire,
    input  logic halted,
    output logic hung
);

    localparam int unsigned          IDLE_W   = 16;
    localparam logic [IDLE_W-1:0]    IDLE_MAX = '1;
    localparam logic [IDLE_W-1:0]    LIMIT    = IDLE_W'(WDOG - 1);
    localparam bit                   WDOG_EN  = (WDOG != 0);

    logic [IDLE_W-1:0] idle;

    // Count consecutive non-retiring cycles; a halted core is not hung.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle <= '0;
        end else if (retire || halted) begin
            idle <= '0;
        end else if (idle != IDLE_MAX) begin
            idle <= idle + 1'b1;
        end
    end

    // Sticky flag raised on the last idle cycle before the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            hung <= 1'b0;
        end else if (WDOG_EN && (idle == LIMIT) && !retire) begin
            hung <= 1'b1;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback/retire stage: one-entry holding register, regfile write port
// arbitration against rf_busy, halt/drain FSM and no-retire watchdog.
module wb_stage
    import core_pkg::*;
#(
    parameter int unsigned WDOG = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              M_v,
    output logic              M_ready,
    input  logic              M_wr,
    input  logic [REG_W-1:0]  M_rt,
    input  logic [DATA_W-1:0] M_val,
    input  logic              M_isHalt,
    input  logic              rf_busy,
    output logic              W_v,
    output logic              W_wen,
    output logic [REG_W-1:0]  W_rt,
    output logic [DATA_W-1:0] W_val,
    output logic              isHalt,
    output logic              halted,
    output logic              hung
);

    wb_state_e state;
    logic      hv;
    wb_entry_t h;
    logic      retire;
    logic      xfer;

    // A writing instruction needs the regfile port; others retire regardless.
    assign retire  = hv && (!h.wr || !rf_busy);
    assign M_ready = (state == WB_RUN) && (!hv || retire);
    assign xfer    = M_v && M_ready;

    assign W_v    = retire;
    assign W_wen  = retire && h.wr;
    assign W_rt   = h.rt;
    assign W_val  = h.val;
    assign isHalt = retire && h.halt;
    assign halted = (state == WB_HALTED);

    // Holding register: load on transfer, empty on retire, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            hv <= 1'b0;
            h  <= '0;
        end else if (xfer) begin
            hv     <= 1'b1;
            h.wr   <= M_wr;
            h.rt   <= M_rt;
            h.val  <= M_val;
            h.halt <= M_isHalt;
        end else if (retire) begin
            hv <= 1'b0;
        end
    end

    // Halt/drain FSM: stop accepting once halt is taken, park after it retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WB_RUN;
        end else begin
            case (state)
                WB_RUN: begin
                    if (xfer && M_isHalt) begin
                        state <= WB_DRAIN;
                    end
                end
                WB_DRAIN: begin
                    if (retire) begin
                        state <= WB_HALTED;
                    end
                end
                WB_HALTED: begin
                    state <= WB_HALTED;
                end
                default: begin
                    state <= WB_RUN;
                end
            endcase
        end
    end

    // Watchdog on retirement activity.
    wb_watchdog #(
        .WDOG(WDOG)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .retire(retire),
        .halted(halted),
        .hung  (hung)
    );

endmodule
